paint_ctrl: RTL and testbench

PAINT_CTRL -- requirements
Module: paint_ctrl

---
 rtl/paint_ctrl_pkg.sv | 35 +++
 rtl/paint_ctrl_key.sv | 83 ++++++++
 rtl/paint_ctrl.sv | 96 +++++++++
 tb/tb_paint_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/paint_ctrl_pkg.sv
// Shared video definitions: coordinate/address/colour widths, controller states
// and the direction-button payload.
package paint_ctrl_pkg;

  localparam int unsigned COORD_W = 8;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned RGB_W   = 12;
  localparam int unsigned TIMER_W = 32;

  localparam logic [COORD_W-1:0] CENTER = COORD_W'(128);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT,
    ST_CLEAR
  } state_t;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
  } dir_t;

  // One axis of a cursor step; opposing buttons cancel, wrap is modulo 2^COORD_W.
  function automatic logic [COORD_W-1:0] step_axis(input logic [COORD_W-1:0] v,
                                                   input logic dec,
                                                   input logic inc);
    if (dec && !inc) return v - COORD_W'(1);
    if (inc && !dec) return v + COORD_W'(1);
    return v;
  endfunction

endpackage

// File: rtl/paint_ctrl_key.sv
// Press / hold / auto-repeat timing for the direction buttons; emits a one-cycle
// step pulse together with the buttons sampled at that step.
module key_repeat
  import paint_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       block,
  input  logic [3:0] dir,
  output logic       step,
  output dir_t       step_dir
);

  state_t             state;
  logic [3:0]         dir_prev;
  logic [TIMER_W-1:0] timer;
  logic               held;

  assign held = |dir;

  // While blocked the edge detector keeps tracking, so a button held across
  // the block needs a release before it can step again.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      timer    <= '0;
      step     <= 1'b0;
      step_dir <= '0;
      dir_prev <= '0;
    end else begin
      dir_prev <= dir;
      step     <= 1'b0;
      if (block) begin
        state <= ST_IDLE;
        timer <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (held && dir_prev == 4'b0000) begin
              step     <= 1'b1;
              step_dir <= dir_t'(dir);
              state    <= ST_HOLD;
              timer    <= TIMER_W'(1);
            end
          end
          ST_HOLD: begin
            if (!held) begin
              state <= ST_IDLE;
              timer <= '0;
            end else if (timer == TIMER_W'(HOLD_DELAY)) begin
              step     <= 1'b1;
              step_dir <= dir_t'(dir);
              state    <= ST_REPEAT;
              timer    <= TIMER_W'(1);
            end else begin
              timer <= timer + TIMER_W'(1);
            end
          end
          ST_REPEAT: begin
            if (!held) begin
              state <= ST_IDLE;
              timer <= '0;
            end else if (timer == TIMER_W'(REPEAT_PERIOD)) begin
              step     <= 1'b1;
              step_dir <= dir_t'(dir);
              timer    <= TIMER_W'(1);
            end else begin
              timer <= timer + TIMER_W'(1);
            end
          end
          default: begin
            state <= ST_IDLE;
            timer <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/paint_ctrl.sv
// Cursor/pen controller for a 256x256 frame buffer: moves the cursor from the
// buttons, writes pen pixels, and sweeps the whole frame to BG_COLOR on clear.
module paint_ctrl
  import paint_ctrl_pkg::*;
#(
  parameter int unsigned      HOLD_DELAY    = 50_000_000,
  parameter int unsigned      REPEAT_PERIOD = 10_000_000,
  parameter logic [RGB_W-1:0] BG_COLOR      = 12'h000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         dir,
  input  logic               draw,
  input  logic               clear,
  input  logic [RGB_W-1:0]   pen_rgb,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               we,
  output logic [ADDR_W-1:0]  waddr,
  output logic [RGB_W-1:0]   wdata,
  output logic               busy
);

  state_t             state;
  logic               step;
  dir_t               step_dir;
  logic               kr_block;
  logic               draw_prev;
  logic               moved;
  logic               pen_write;
  logic [COORD_W-1:0] nx;
  logic [COORD_W-1:0] ny;

  assign kr_block  = clear || (state == ST_CLEAR);
  assign nx        = step_axis(x, step_dir.left, step_dir.right);
  assign ny        = step_axis(y, step_dir.up, step_dir.down);
  assign pen_write = draw && (moved || !draw_prev);

  key_repeat #(
    .HOLD_DELAY   (HOLD_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_key_repeat (
    .clk     (clk),
    .rst     (rst),
    .block   (kr_block),
    .dir     (dir),
    .step    (step),
    .step_dir(step_dir)
  );

  // Pen writes land one cycle after the cursor moves, so waddr is always the
  // registered {y,x} that the display unit already sees.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      x         <= CENTER;
      y         <= CENTER;
      we        <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      busy      <= 1'b0;
      draw_prev <= 1'b0;
      moved     <= 1'b0;
    end else begin
      draw_prev <= draw;
      if (state == ST_CLEAR) begin
        if (&waddr) begin
          state <= ST_IDLE;
          we    <= 1'b0;
          busy  <= 1'b0;
        end else begin
          waddr <= waddr + ADDR_W'(1);
        end
      end else if (clear) begin
        state <= ST_CLEAR;
        busy  <= 1'b1;
        we    <= 1'b1;
        waddr <= '0;
        wdata <= BG_COLOR;
        moved <= 1'b0;
      end else begin
        moved <= step && ((nx != x) || (ny != y));
        if (step) begin
          x <= nx;
          y <= ny;
        end
        we <= pen_write;
        if (pen_write) begin
          waddr <= {y, x};
          wdata <= pen_rgb;
        end
      end
    end
  end

endmodule

// File: tb/tb_paint_ctrl.sv
// Self-checking bench for paint_ctrl: directed table, multi-cycle sequences and
// a randomized run against a run-length reference model.
module tb_paint_ctrl;

  localparam int unsigned HOLD   = 8;
  localparam int unsigned PERIOD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  dir;
  logic        draw;
  logic        clear;
  logic [11:0] pen_rgb;
  logic [7:0]  x;
  logic [7:0]  y;
  logic        we;
  logic [15:0] waddr;
  logic [11:0] wdata;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  paint_ctrl #(
    .HOLD_DELAY   (HOLD),
    .REPEAT_PERIOD(PERIOD),
    .BG_COLOR     (12'h000)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .dir    (dir),
    .draw   (draw),
    .clear  (clear),
    .pen_rgb(pen_rgb),
    .x      (x),
    .y      (y),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; dir = 4'b0000; draw = 1'b0; clear = 1'b0; pen_rgb = 12'h000;
    tick();
    rst = 1'b0;
  endtask

  task automatic press(input logic [3:0] d);
    dir = d;
    tick();
    dir = 4'b0000;
    tick();
    tick();
  endtask

  // Reference model: steps happen at fixed offsets into an uninterrupted press
  // (offset 0, HOLD, HOLD+PERIOD, ...); cursor moves one edge after the step,
  // a pen write follows a move by one more edge, or follows a draw rise directly.
  int          m_run;
  bit          m_prev_zero;
  bit          m_draw_prev;
  bit          m_pend_step;
  logic [3:0]  m_pend_dir;
  bit          m_pend_move;
  int          mx, my;
  bit          mwe;
  logic [15:0] mwaddr;
  logic [11:0] mwdata;

  function automatic bit step_time(input int n);
    if (n == 1) return 1'b1;
    if (n - 1 < int'(HOLD)) return 1'b0;
    return ((n - 1 - int'(HOLD)) % int'(PERIOD)) == 0;
  endfunction

  task automatic model_edge(input bit r, input logic [3:0] d, input bit dr, input logic [11:0] pen);
    int nx, ny;
    bit move_now;
    if (r) begin
      m_run = 0; m_prev_zero = 1'b1; m_draw_prev = 1'b0;
      m_pend_step = 1'b0; m_pend_dir = 4'b0000; m_pend_move = 1'b0;
      mx = 128; my = 128; mwe = 1'b0; mwaddr = 16'h0000; mwdata = 12'h000;
      return;
    end
    mwe = dr && (m_pend_move || !m_draw_prev);
    if (mwe) begin
      mwaddr = {8'(my), 8'(mx)};
      mwdata = pen;
    end
    move_now = 1'b0;
    if (m_pend_step) begin
      nx = (mx + int'(m_pend_dir[0]) - int'(m_pend_dir[1]) + 256) % 256;
      ny = (my + int'(m_pend_dir[2]) - int'(m_pend_dir[3]) + 256) % 256;
      move_now = (nx != mx) || (ny != my);
      mx = nx;
      my = ny;
    end
    m_pend_move = move_now;
    if (d == 4'b0000) m_run = 0;
    else if (m_run > 0) m_run++;
    else if (m_prev_zero) m_run = 1;
    m_pend_step = (m_run > 0) && step_time(m_run);
    m_pend_dir  = d;
    m_prev_zero = (d == 4'b0000);
    m_draw_prev = dr;
  endtask

  typedef struct {
    logic [3:0]  dir;
    logic        draw;
    logic [11:0] pen;
    logic [7:0]  ex;
    logic [7:0]  ey;
    logic        ewe;
    logic [15:0] ea;
    logic [11:0] ed;
  } vec_t;

  vec_t vt[16];
  int   step_at[4];

  initial begin
    int ysteps, good, first_bad, n;
    bit r;

    vt[0]  = '{4'b0000, 1'b1, 12'hF00, 8'h80, 8'h80, 1'b1, 16'h8080, 12'hF00};
    vt[1]  = '{4'b0000, 1'b1, 12'hF00, 8'h80, 8'h80, 1'b0, 16'h8080, 12'hF00};
    vt[2]  = '{4'b0001, 1'b1, 12'hF00, 8'h80, 8'h80, 1'b0, 16'h8080, 12'hF00};
    vt[3]  = '{4'b0000, 1'b1, 12'hF00, 8'h81, 8'h80, 1'b0, 16'h8080, 12'hF00};
    vt[4]  = '{4'b0000, 1'b1, 12'hF00, 8'h81, 8'h80, 1'b1, 16'h8081, 12'hF00};
    vt[5]  = '{4'b0000, 1'b1, 12'hF00, 8'h81, 8'h80, 1'b0, 16'h8081, 12'hF00};
    vt[6]  = '{4'b1101, 1'b0, 12'h0F0, 8'h81, 8'h80, 1'b0, 16'h8081, 12'hF00};
    vt[7]  = '{4'b0000, 1'b0, 12'h0F0, 8'h82, 8'h80, 1'b0, 16'h8081, 12'hF00};
    vt[8]  = '{4'b0000, 1'b0, 12'h0F0, 8'h82, 8'h80, 1'b0, 16'h8081, 12'hF00};
    vt[9]  = '{4'b1011, 1'b1, 12'h0F0, 8'h82, 8'h80, 1'b1, 16'h8082, 12'h0F0};
    vt[10] = '{4'b0000, 1'b1, 12'h0F0, 8'h82, 8'h7F, 1'b0, 16'h8082, 12'h0F0};
    vt[11] = '{4'b0000, 1'b1, 12'h0F0, 8'h82, 8'h7F, 1'b1, 16'h7F82, 12'h0F0};
    vt[12] = '{4'b0000, 1'b0, 12'h0F0, 8'h82, 8'h7F, 1'b0, 16'h7F82, 12'h0F0};
    vt[13] = '{4'b1010, 1'b0, 12'h0F0, 8'h82, 8'h7F, 1'b0, 16'h7F82, 12'h0F0};
    vt[14] = '{4'b0000, 1'b0, 12'h0F0, 8'h81, 8'h7E, 1'b0, 16'h7F82, 12'h0F0};
    vt[15] = '{4'b0000, 1'b0, 12'h0F0, 8'h81, 8'h7E, 1'b0, 16'h7F82, 12'h0F0};
    step_at = '{0, 8, 12, 16};

    // Reset state and directed table
    do_reset();
    chk("reset_state", {x, y, we, waddr, wdata, busy}, {8'h80, 8'h80, 1'b0, 16'h0000, 12'h000, 1'b0});
    for (int i = 0; i < 16; i++) begin
      dir = vt[i].dir; draw = vt[i].draw; pen_rgb = vt[i].pen;
      tick();
      chk($sformatf("table_row%0d", i), {x, y, we, waddr, wdata, busy},
          {vt[i].ex, vt[i].ey, vt[i].ewe, vt[i].ea, vt[i].ed, 1'b0});
    end

    // Hold up for 20 cycles then release
    do_reset();
    for (int i = 0; i < 30; i++) begin
      dir = (i < 20) ? 4'b1000 : 4'b0000;
      tick();
      ysteps = 0;
      foreach (step_at[j]) if (step_at[j] + 1 <= i) ysteps++;
      chk($sformatf("hold_up_cyc%0d", i), {x, y, we}, {8'h80, 8'(128 - ysteps), 1'b0});
    end

    // Wrap-around on both axes
    do_reset();
    for (int i = 0; i < 127; i++) press(4'b0001);
    chk("x_at_255", x, 8'hFF);
    press(4'b0001);
    chk("x_wrap_to_0", x, 8'h00);
    for (int i = 0; i < 128; i++) press(4'b1000);
    chk("y_at_0", y, 8'h00);
    press(4'b1000);
    chk("y_wrap_to_255", y, 8'hFF);

    // Clear coinciding with a step pulse, held dir across the sweep
    do_reset();
    dir = 4'b0001;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    good = 0; first_bad = -1;
    for (int i = 0; i < 65536; i++) begin
      if (we === 1'b1 && busy === 1'b1 && waddr === 16'(i) && wdata === 12'h000 &&
          x === 8'h80 && y === 8'h80) good++;
      else if (first_bad < 0) first_bad = i;
      draw  = (i < 65500) ? 1'(i >> 3) : 1'b0;
      clear = (i == 1000);
      tick();
    end
    clear = 1'b0;
    if (first_bad >= 0) $display("first bad sweep cycle %0d", first_bad);
    chk("clear_sweep_cycles", 64'(good), 64'd65536);
    chk("clear_end", {we, busy, x, y}, {1'b0, 1'b0, 8'h80, 8'h80});
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("held_after_clear%0d", i), {x, we}, {8'h80, 1'b0});
    end
    dir = 4'b0000;
    tick();
    press(4'b0001);
    chk("repress_after_clear", x, 8'h81);

    // Reset aborting a sweep
    do_reset();
    press(4'b0001);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n = 0;
    while (waddr !== 16'h1234 && n < 70000) begin
      tick();
      n++;
    end
    chk("clear_reach_1234", {waddr, we, busy}, {16'h1234, 1'b1, 1'b1});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset_abort", {we, busy, x, y, waddr}, {1'b0, 1'b0, 8'h80, 8'h80, 16'h0000});
    tick(); tick(); tick();
    chk("idle_after_abort", {we, busy, waddr}, {1'b0, 1'b0, 16'h0000});

    // Randomized run against the reference model
    do_reset();
    model_edge(1'b1, 4'b0000, 1'b0, 12'h000);
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(0, 299) == 0);
      rst = r;
      if ($urandom_range(0, 7) == 0)
        dir = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
      if ($urandom_range(0, 5) == 0) draw = ~draw;
      pen_rgb = 12'($urandom);
      tick();
      model_edge(r, dir, draw, pen_rgb);
      chk($sformatf("random_cyc%0d", c), {x, y, we, waddr, wdata, busy},
          {8'(mx), 8'(my), mwe, mwaddr, mwdata, 1'b0});
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
